// File: rtl/uart_interface_pkg.sv
// Shared definitions for the memory-mapped UART: status bit positions,
// TX/RX state encodings, the reset divisor and a timing helper.
package uart_interface_pkg;

  // Reset bit-period divisor: bit period = divisor + 1 clocks (6.25 MHz -> 115200 baud)
  localparam int unsigned UART_DEFAULT_DIVISOR = 53;

  // Status register bit positions
  localparam int ST_RX_READY     = 0;
  localparam int ST_TX_FULL      = 1;
  localparam int ST_TX_BUSY      = 2;
  localparam int ST_RX_OVERRUN   = 3;
  localparam int ST_FRAMING_ERR  = 4;
  localparam int ST_RX_COUNT_LSB = 8;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // Delay from the detected start edge to the start-bit sample point
  function automatic logic [15:0] half_period(input logic [15:0] div);
    return div >> 1;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Byte FIFO buffering received UART characters. DEPTH must be a power of two.
// A push while full is accepted only when a pop happens in the same cycle.
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          n_reset,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    push_data,
  output logic [7:0]    pop_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // Storage array; contents need no reset because occupancy gates every read
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_interface.sv
// Memory-mapped 8N1 UART with a programmable bit-period divisor.
// Build option: define UART_RX_FIFO_EN for an RX_FIFO_DEPTH-entry receive FIFO;
// otherwise a single receive holding register is used.
module uart_interface
  import uart_interface_pkg::*;
#(
  parameter int unsigned DEFAULT_DIVISOR = UART_DEFAULT_DIVISOR,
  parameter int unsigned RX_FIFO_DEPTH   = 8
) (
  input  logic        clock,
  input  logic        n_reset,
  input  logic        read,
  input  logic        write,
  input  logic        data_cs,
  input  logic        status_cs,
  input  logic        divisor_cs,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        data_out_valid,
  output logic        tx,
  input  logic        rx
);

  if (RX_FIFO_DEPTH < 2 || (RX_FIFO_DEPTH & (RX_FIFO_DEPTH - 1)) != 0) begin : g_depth_check
    $error("RX_FIFO_DEPTH must be a power of two of at least 2");
  end

  function automatic logic [3:0] sat_count4(input int unsigned n);
    return (n > 15) ? 4'd15 : n[3:0];
  endfunction

  logic [15:0] divisor;
  tx_state_t   tx_state;
  logic [15:0] tx_cnt;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_hold;
  logic [7:0]  tx_shift;
  logic        tx_full;
  logic        tx_tick, tx_load;
  logic        rx_s1, rx_s2, rx_s3;
  rx_state_t   rx_state;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_shift;
  logic        rx_tick, rx_stop_tick, rx_fall;
  logic        rx_overrun, framing_err;
  logic        push, pop, rx_empty, rx_full;
  logic [7:0]  rx_head;
  logic [3:0]  rx_count;
  logic [31:0] status_word;
  logic        wr_data, rd_status;
  logic        unused_bits;

  assign unused_bits    = &{1'b0, data_in[31:16]};
  assign wr_data        = write && data_cs;
  assign rd_status      = read && status_cs;
  assign pop            = read && data_cs && !rx_empty;
  assign data_out_valid = read && (data_cs || status_cs || divisor_cs);

  assign tx_tick      = (tx_cnt == 16'd0);
  assign tx_load      = tx_full && ((tx_state == TX_IDLE) || (tx_state == TX_STOP && tx_tick));
  assign rx_tick      = (rx_cnt == 16'd0);
  assign rx_fall      = rx_s3 && !rx_s2;
  assign rx_stop_tick = (rx_state == RX_STOP) && rx_tick;
  assign push         = rx_stop_tick && rx_s2;

  // Status word assembly
  always_comb begin
    status_word = '0;
    status_word[ST_RX_READY]    = !rx_empty;
    status_word[ST_TX_FULL]     = tx_full;
    status_word[ST_TX_BUSY]     = (tx_state != TX_IDLE);
    status_word[ST_RX_OVERRUN]  = rx_overrun;
    status_word[ST_FRAMING_ERR] = framing_err;
    status_word[ST_RX_COUNT_LSB +: 4] = rx_count;
  end

  // Read mux; zero whenever no register is being read
  always_comb begin
    data_out = '0;
    if (read) begin
      if (data_cs)         data_out = {24'h0, rx_empty ? 8'h00 : rx_head};
      else if (status_cs)  data_out = status_word;
      else if (divisor_cs) data_out = {16'h0, divisor};
    end
  end

  // Divisor register; counters pick up a new value at their next reload
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset)                divisor <= DEFAULT_DIVISOR[15:0];
    else if (write && divisor_cs) divisor <= data_in[15:0];
  end

  // TX holding register and shifter data
  always_ff @(posedge clock) begin
    if (wr_data && !tx_full) tx_hold <= data_in[7:0];
    if (tx_load) tx_shift <= tx_hold;
    else if (tx_state == TX_DATA && tx_tick) tx_shift <= tx_shift >> 1;
  end

  // TX FSM; STOP chains straight into START when another byte is waiting
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_full  <= 1'b0;
      tx       <= 1'b1;
    end else begin
      if (tx_load)      tx_full <= 1'b0;
      else if (wr_data) tx_full <= 1'b1;
      case (tx_state)
        TX_IDLE: if (tx_full) begin
          tx_state <= TX_START;
          tx_cnt   <= divisor;
          tx       <= 1'b0;
        end
        TX_START: if (tx_tick) begin
          tx_state <= TX_DATA;
          tx_cnt   <= divisor;
          tx_bit   <= '0;
          tx       <= tx_shift[0];
        end else tx_cnt <= tx_cnt - 16'd1;
        TX_DATA: if (tx_tick) begin
          tx_cnt <= divisor;
          if (tx_bit == 3'd7) begin
            tx_state <= TX_STOP;
            tx       <= 1'b1;
          end else begin
            tx_bit <= tx_bit + 3'd1;
            tx     <= tx_shift[1];
          end
        end else tx_cnt <= tx_cnt - 16'd1;
        TX_STOP: if (tx_tick) begin
          if (tx_full) begin
            tx_state <= TX_START;
            tx_cnt   <= divisor;
            tx       <= 1'b0;
          end else tx_state <= TX_IDLE;
        end else tx_cnt <= tx_cnt - 16'd1;
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // Two-flop synchroniser plus one delay stage for falling-edge detection
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  // RX data shifter, LSB arrives first
  always_ff @(posedge clock) begin
    if (rx_state == RX_DATA && rx_tick) rx_shift <= {rx_s2, rx_shift[7:1]};
  end

  // RX FSM; a start bit that is high again at mid-bit is treated as a glitch
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
    end else begin
      case (rx_state)
        RX_IDLE: if (rx_fall) begin
          rx_state <= RX_START;
          rx_cnt   <= half_period(divisor);
        end
        RX_START: if (rx_tick) begin
          rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
          rx_cnt   <= divisor;
          rx_bit   <= '0;
        end else rx_cnt <= rx_cnt - 16'd1;
        RX_DATA: if (rx_tick) begin
          rx_cnt <= divisor;
          if (rx_bit == 3'd7) rx_state <= RX_STOP;
          else                rx_bit   <= rx_bit + 3'd1;
        end else rx_cnt <= rx_cnt - 16'd1;
        RX_STOP: if (rx_tick) rx_state <= RX_IDLE;
                 else         rx_cnt   <= rx_cnt - 16'd1;
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Sticky error flags; a new event wins over a clearing status read
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      rx_overrun  <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      if (push && rx_full && !pop) rx_overrun <= 1'b1;
      else if (rd_status)          rx_overrun <= 1'b0;
      if (rx_stop_tick && !rx_s2)  framing_err <= 1'b1;
      else if (rd_status)          framing_err <= 1'b0;
    end
  end

`ifdef UART_RX_FIFO_EN
  logic [$clog2(RX_FIFO_DEPTH):0] fifo_count;

  uart_rx_fifo #(.DEPTH(RX_FIFO_DEPTH)) u_rx_fifo (
    .clock     (clock),
    .n_reset   (n_reset),
    .push      (push),
    .pop       (pop),
    .push_data (rx_shift),
    .pop_data  (rx_head),
    .full      (rx_full),
    .empty     (rx_empty),
    .count     (fifo_count)
  );

  assign rx_count = sat_count4(32'(fifo_count));
`else
  logic       rx_valid;
  logic [7:0] rx_hold;

  // Holding-register occupancy; simultaneous pop and push keeps it full
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset)  rx_valid <= 1'b0;
    else if (push) rx_valid <= 1'b1;
    else if (pop)  rx_valid <= 1'b0;
  end

  // Holding-register data; a push into a full, unread register is dropped
  always_ff @(posedge clock) begin
    if (push && (!rx_valid || pop)) rx_hold <= rx_shift;
  end

  assign rx_head  = rx_hold;
  assign rx_full  = rx_valid;
  assign rx_empty = !rx_valid;
  assign rx_count = sat_count4(32'(rx_valid));
`endif

endmodule

// File: tb/tb_uart_interface.sv
// Directed + randomized bench for uart_interface with a queue-based reference model.
module tb_uart_interface;

  logic        clock = 1'b0;
  logic        n_reset = 1'b0;
  logic        read = 1'b0, write = 1'b0;
  logic        data_cs = 1'b0, status_cs = 1'b0, divisor_cs = 1'b0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;
  logic        data_out_valid;
  logic        tx;
  logic        rx = 1'b1;

`ifdef UART_RX_FIFO_EN
  localparam int  CAP  = 8;
  localparam bit  FIFO = 1'b1;
`else
  localparam int  CAP  = 1;
  localparam bit  FIFO = 1'b0;
`endif

  uart_interface dut (
    .clock          (clock),
    .n_reset        (n_reset),
    .read           (read),
    .write          (write),
    .data_cs        (data_cs),
    .status_cs      (status_cs),
    .divisor_cs     (divisor_cs),
    .data_in        (data_in),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .tx             (tx),
    .rx             (rx)
  );

  always #5 clock = ~clock;

  int compared = 0;
  int mismatched = 0;

  // Reference model state
  logic [7:0] model_q[$];
  bit         m_overrun = 1'b0;
  bit         m_ferr = 1'b0;
  int         div_m = 53;

  // Negedge tx logger for the back-to-back test
  bit   log_en = 1'b0;
  logic tx_q[$];
  always @(negedge clock) if (log_en) tx_q.push_back(tx);

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic select(input int sel);
    data_cs    = (sel == 0);
    status_cs  = (sel == 1);
    divisor_cs = (sel == 2);
  endtask

  task automatic bus_write(input int sel, input logic [31:0] val);
    select(sel);
    write = 1'b1;
    data_in = val;
    tick();
    write = 1'b0;
    select(-1);
  endtask

  task automatic bus_read(input int sel, output logic [31:0] d, output logic v);
    select(sel);
    read = 1'b1;
    #1;
    d = data_out;
    v = data_out_valid;
    tick();
    read = 1'b0;
    select(-1);
  endtask

  function automatic logic [31:0] exp_status(input bit busy, input bit full);
    logic [31:0] s;
    int n;
    s = '0;
    n = model_q.size();
    s[0] = (n != 0);
    s[1] = full;
    s[2] = busy;
    s[3] = m_overrun;
    s[4] = m_ferr;
    s[11:8] = FIFO ? ((n > 15) ? 4'd15 : 4'(n)) : {3'b000, (n != 0)};
    return s;
  endfunction

  task automatic status_check(input string tag, input bit busy, input bit full);
    logic [31:0] d, e;
    logic v;
    e = exp_status(busy, full);
    bus_read(1, d, v);
    check({tag, " status"}, d, e);
    check({tag, " status valid"}, 32'(v), 32'd1);
    m_overrun = 1'b0;
    m_ferr = 1'b0;
  endtask

  task automatic data_check(input string tag);
    logic [31:0] d, e;
    logic v;
    e = (model_q.size() != 0) ? {24'h0, model_q[0]} : 32'h0;
    bus_read(0, d, v);
    check({tag, " data"}, d, e);
    check({tag, " data valid"}, 32'(v), 32'd1);
    if (model_q.size() != 0) void'(model_q.pop_front());
  endtask

  // Drive one serial frame on rx and apply the model's receive rules
  task automatic send_rx(input logic [7:0] b, input bit stop_bit);
    int p;
    p = div_m + 1;
    rx = 1'b0;
    repeat (p) tick();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (p) tick();
    end
    rx = stop_bit;
    repeat (p) tick();
    rx = 1'b1;
    repeat (2 * p) tick();
    if (!stop_bit)                   m_ferr = 1'b1;
    else if (model_q.size() < CAP)   model_q.push_back(b);
    else                             m_overrun = 1'b1;
  endtask

  // Send one byte and check the whole wire frame plus busy duration
  task automatic tx_capture(input logic [7:0] b, input string tag);
    int p, n, s, busy;
    logic tl[$];
    logic bl[$];
    logic [9:0] frame;
    logic [31:0] obs, exp;
    p = div_m + 1;
    n = 10 * p + 12;
    s = -1;
    busy = 0;
    frame = {1'b1, b, 1'b0};
    bus_write(0, {8'($urandom), 16'($urandom), b});
    select(1);
    read = 1'b1;
    for (int i = 0; i < n; i++) begin
      tl.push_back(tx);
      bl.push_back(data_out[2]);
      tick();
    end
    read = 1'b0;
    select(-1);
    for (int i = 0; i < n; i++) begin
      if (s < 0 && tl[i] == 1'b0) s = i;
      if (bl[i] === 1'b1) busy++;
    end
    check({tag, " start found"}, 32'(s >= 0), 32'd1);
    if (s < 0) s = 0;
    for (int k = 0; k < 10; k++) begin
      obs = '0;
      for (int j = 0; j < p; j++)
        obs[j] = (s + k * p + j < n) ? tl[s + k * p + j] : 1'bx;
      exp = frame[k] ? ((32'd1 << p) - 32'd1) : 32'd0;
      check($sformatf("%s bit%0d", tag, k), obs, exp);
    end
    check({tag, " busy clocks"}, 32'(busy), 32'(10 * p));
  endtask

  initial begin
    logic [31:0] d;
    logic v;
    int s, ones, polls;
    logic [31:0] obs, exp;
    logic [7:0] b;
    logic [29:0] stream;

    // Reset state
    repeat (3) tick();
    check("reset tx", 32'(tx), 32'd1);
    n_reset = 1'b1;
    tick();
    status_check("reset", 1'b0, 1'b0);
    bus_read(2, d, v);
    check("reset divisor", d, 32'd53);
    data_check("reset empty");
    read = 1'b1;
    #1;
    check("no-cs data_out", data_out, 32'h0);
    check("no-cs valid", 32'(data_out_valid), 32'd0);
    tick();
    read = 1'b0;

    // Divisor 3, TX frames
    bus_write(2, 32'hABCD_0003);
    div_m = 3;
    bus_read(2, d, v);
    check("divisor readback", d, 32'd3);
    tx_capture(8'hA5, "tx A5");
    tx_capture(8'($urandom), "tx rand");

    // Back-to-back frames, third write dropped while tx_full
    tx_q.delete();
    log_en = 1'b1;
    bus_write(0, 32'h11);
    polls = 0;
    do begin
      bus_read(1, d, v);
      polls++;
    end while (d[1] && polls < 20);
    check("tx_full cleared", 32'(d[1]), 32'd0);
    bus_write(0, 32'h22);
    bus_write(0, 32'h33);
    bus_read(1, d, v);
    check("tx_full held", 32'(d[1]), 32'd1);
    repeat (110) tick();
    log_en = 1'b0;
    stream = {1'b1, 8'h22, 1'b0, 1'b1, 8'h11, 1'b0, 10'h3FF};
    s = -1;
    foreach (tx_q[i]) if (s < 0 && tx_q[i] == 1'b0) s = i;
    check("b2b start found", 32'(s >= 0), 32'd1);
    if (s < 0) s = 0;
    for (int k = 0; k < 20; k++) begin
      obs = '0;
      for (int j = 0; j < 4; j++)
        obs[j] = (s + 4 * k + j < tx_q.size()) ? tx_q[s + 4 * k + j] : 1'bx;
      exp = stream[10 + k] ? 32'hF : 32'h0;
      check($sformatf("b2b bit%0d", k), obs, exp);
    end
    ones = 0;
    for (int j = 0; j < 12; j++)
      if (s + 80 + j < tx_q.size() && tx_q[s + 80 + j] === 1'b1) ones++;
    check("third byte dropped", 32'(ones), 32'd12);

    // RX good frames
    send_rx(8'h3C, 1'b1);
    status_check("rx 3C", 1'b0, 1'b0);
    data_check("rx 3C");
    status_check("rx 3C after pop", 1'b0, 1'b0);
    for (int r = 0; r < 3; r++) begin
      b = 8'($urandom);
      send_rx(b, 1'b1);
      data_check($sformatf("rx rand%0d", r));
    end

    // Framing error
    send_rx(8'h55, 1'b0);
    status_check("ferr first", 1'b0, 1'b0);
    status_check("ferr second", 1'b0, 1'b0);

    // Overrun
    for (int r = 0; r <= CAP; r++) send_rx(8'($urandom), 1'b1);
    status_check("overrun", 1'b0, 1'b0);
    for (int r = 0; r <= CAP; r++) data_check($sformatf("overrun read%0d", r));
    status_check("overrun cleared", 1'b0, 1'b0);

    // One-clock glitch on rx
    rx = 1'b0;
    tick();
    rx = 1'b1;
    repeat (20) tick();
    status_check("glitch", 1'b0, 1'b0);

    // Divisor 0: one clock per bit
    bus_write(2, 32'h0);
    div_m = 0;
    tx_capture(8'($urandom), "tx div0");

    // Reset in the middle of a TX frame
    bus_write(2, 32'h3);
    div_m = 3;
    bus_write(0, 32'hF0);
    repeat (10) tick();
    bus_read(1, d, v);
    check("midframe busy", 32'(d[2]), 32'd1);
    n_reset = 1'b0;
    #1;
    check("reset tx immediate", 32'(tx), 32'd1);
    select(1);
    read = 1'b1;
    #1;
    check("status in reset", data_out, 32'h0);
    tick();
    read = 1'b0;
    select(-1);
    n_reset = 1'b1;
    model_q.delete();
    m_overrun = 1'b0;
    m_ferr = 1'b0;
    div_m = 53;
    status_check("after reset", 1'b0, 1'b0);
    bus_read(2, d, v);
    check("divisor after reset", d, 32'd53);
    ones = 0;
    for (int j = 0; j < 30; j++) begin
      if (tx === 1'b1) ones++;
      tick();
    end
    check("tx idle after reset", 32'(ones), 32'd30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
